// File: rtl/local_mem_port_arbiter.sv
// Round-robin arbiter sharing one local-memory port among NUM_REQ requesters, with optional zero-fill after reset.
// Grant is combinational; the response arrives one cycle after acceptance. Only the granted requester sees ready.
module local_mem_port_arbiter #(
   parameter int LINES          = 4096,
   parameter int NUM_REQ        = 3,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int AW            = (LINES > 1) ? $clog2(LINES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*AW-1:0]   req_addr,
   input  logic [NUM_REQ*4-1:0]    req_be,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    ram_en,
   output logic [AW-1:0]           ram_addr,
   output logic [3:0]              ram_be,
   output logic [31:0]             ram_data_in,
   input  logic [31:0]             ram_data_out,
   output logic                    init_done
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {CLEAR, SERVE} state_t;

   state_t               state_q;
   logic [AW-1:0]        cnt_q;
   logic [RW-1:0]        rr_q;
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic                 init_done_q;

   logic                 gnt_any;
   logic [RW-1:0]        gnt_idx;
   logic [RW-1:0]        rr_d;
   int                   idx;

   // Search starts at rr_q and wraps, so the last-served requester has lowest priority.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_q) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = RW'(idx);
         end
      end
   end

   always_comb begin
      rr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
   end

   always_comb begin
      req_ready   = '0;
      ram_en      = 1'b0;
      ram_addr    = '0;
      ram_be      = '0;
      ram_data_in = '0;
      if (state_q == CLEAR) begin
         ram_en   = 1'b1;
         ram_addr = cnt_q;
         ram_be   = 4'hF;
      end else if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
         ram_en      = 1'b1;
         ram_addr    = req_addr[int'(gnt_idx)*AW +: AW];
         ram_be      = req_be[int'(gnt_idx)*4 +: 4];
         ram_data_in = req_wdata[int'(gnt_idx)*32 +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR_ON_RESET ? CLEAR : SERVE;
         cnt_q       <= '0;
         rr_q        <= '0;
         rsp_valid_q <= '0;
         init_done_q <= !CLEAR_ON_RESET;
      end else begin
         case (state_q)
            CLEAR: begin
               rsp_valid_q <= '0;
               // Compare against the last line rather than relying on wrap, so LINES need not be 2^n.
               if (cnt_q == AW'(LINES - 1)) begin
                  cnt_q       <= '0;
                  state_q     <= SERVE;
                  init_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               rsp_valid_q <= req_ready;
               if (gnt_any) rr_q <= rr_d;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = ram_data_out;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_local_mem_port_arbiter.sv
// Directed bench for local_mem_port_arbiter: clear phase, reads, round robin, byte writes, reset and odd LINES.
module tb_local_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst2_n = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [2:0]  req_ready;
   logic [11:0] req_addr = '0;
   logic [11:0] req_be = '0;
   logic [95:0] req_wdata = '0;
   logic [2:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        ram_en;
   logic [3:0]  ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out = '0;
   logic        init_done;

   logic [2:0]  req_valid2 = '0;
   logic [2:0]  req_ready2;
   logic [11:0] req_addr2 = '0;
   logic [11:0] req_be2 = '0;
   logic [95:0] req_wdata2 = '0;
   logic [2:0]  rsp_valid2;
   logic [31:0] rsp_rdata2;
   logic        ram_en2;
   logic [3:0]  ram_addr2;
   logic [3:0]  ram_be2;
   logic [31:0] ram_data_in2;
   logic [31:0] ram_data_out2 = '0;
   logic        init_done2;
   logic        bad2 = 1'b0;

   logic [31:0] mem [16];
   logic [31:0] merged;
   logic        pl_en = 1'b0;
   logic [3:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   local_mem_port_arbiter #(.LINES(16), .NUM_REQ(3), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_en(ram_en),
      .ram_addr(ram_addr), .ram_be(ram_be), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .init_done(init_done));

   local_mem_port_arbiter #(.LINES(10), .NUM_REQ(3), .CLEAR_ON_RESET(1'b1)) dut10 (
      .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_addr(req_addr2), .req_be(req_be2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .ram_en(ram_en2),
      .ram_addr(ram_addr2), .ram_be(ram_be2), .ram_data_in(ram_data_in2),
      .ram_data_out(ram_data_out2), .init_done(init_done2));

   // Memory port model: registered read, write-first per byte lane.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_en) begin
         merged = mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) merged[b*8 +: 8] = ram_data_in[b*8 +: 8];
         mem[ram_addr] <= merged;
         ram_data_out  <= merged;
      end
   end

   always @(posedge clk)
      if (rst2_n && ram_en2 && ram_addr2 >= 4'd10) bad2 <= 1'b1;

   task automatic preload(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_chk++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
      n_chk++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
      n_chk++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
      n_chk++; if (ram_addr !== 4'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
   endtask

   task automatic test_clear;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 3'b100; req_addr[8 +: 4] = 4'd3; req_be[8 +: 4] = 4'h0;
      for (int c = 0; c < 16; c++) begin
         #1;
         n_chk++; if (ram_en !== 1'b1 || ram_addr !== 4'(c) || ram_be !== 4'hF || ram_data_in !== 32'h0) begin
            n_fail++; $display("FAIL clear_write[%0d]: got en=%b addr=%0d be=%h d=%h want en=1 addr=%0d be=f d=0", c, ram_en, ram_addr, ram_be, ram_data_in, c);
         end
         n_chk++; if (req_ready !== 3'b000 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_ready[%0d]: got ready=%b init=%b want 000/0", c, req_ready, init_done);
         end
         @(negedge clk);
      end
      #1;
      n_chk++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clear_init_done: got %b want 1", init_done); end
      n_chk++; if (req_ready !== 3'b100 || ram_addr !== 4'd3) begin
         n_fail++; $display("FAIL first_serve_grant: got ready=%b addr=%0d want 100/3", req_ready, ram_addr);
      end
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b100) begin n_fail++; $display("FAIL first_serve_rsp: got %b want 100", rsp_valid); end
      @(negedge clk);
      req_valid = 3'b000;
   endtask

   task automatic test_round_robin;
      logic [2:0] exp;
      @(negedge clk);
      req_valid = 3'b111;
      req_addr = {4'd3, 4'd2, 4'd1};
      req_be = '0;
      for (int k = 0; k < 6; k++) begin
         exp = 3'b001 << (k % 3);
         #1;
         n_chk++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp); end
         @(posedge clk); #1;
         n_chk++; if (rsp_valid !== exp) begin n_fail++; $display("FAIL rr_rsp[%0d]: got %b want %b", k, rsp_valid, exp); end
         @(negedge clk);
      end
      req_valid = 3'b000;
   endtask

   task automatic test_single_read;
      preload(4'd5, 32'hDEADBEEF);
      req_valid = 3'b001; req_addr[0 +: 4] = 4'd5; req_be[0 +: 4] = 4'h0;
      #1;
      n_chk++; if (req_ready !== 3'b001 || ram_en !== 1'b1 || ram_addr !== 4'd5 || ram_be !== 4'h0) begin
         n_fail++; $display("FAIL read_grant: got ready=%b en=%b addr=%0d be=%h want 001/1/5/0", req_ready, ram_en, ram_addr, ram_be);
      end
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL read_rsp_valid: got %b want 001", rsp_valid); end
      n_chk++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h want deadbeef", rsp_rdata); end
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      n_chk++; if (ram_en !== 1'b0 || req_ready !== 3'b000) begin
         n_fail++; $display("FAIL idle: got en=%b ready=%b want 0/000", ram_en, req_ready);
      end
   endtask

   task automatic test_back_to_back;
      preload(4'd9, 32'h11223344);
      req_valid = 3'b010; req_addr[4 +: 4] = 4'd9; req_be[4 +: 4] = 4'b0010; req_wdata[32 +: 32] = 32'h0000AB00;
      #1;
      n_chk++; if (req_ready !== 3'b010 || ram_be !== 4'b0010 || ram_data_in !== 32'h0000AB00 || ram_addr !== 4'd9) begin
         n_fail++; $display("FAIL write_grant: got ready=%b be=%b d=%h addr=%0d want 010/0010/0000ab00/9", req_ready, ram_be, ram_data_in, ram_addr);
      end
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h1122AB44) begin
         n_fail++; $display("FAIL write_echo: got v=%b d=%h want 010/1122ab44", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      req_be[4 +: 4] = 4'h0;
      #1;
      n_chk++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL b2b_grant: got %b want 010", req_ready); end
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h1122AB44) begin
         n_fail++; $display("FAIL readback: got v=%b d=%h want 010/1122ab44", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      req_valid = 3'b000;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      req_valid = 3'b001; req_addr[0 +: 4] = 4'd5; req_be[0 +: 4] = 4'h0;
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL pre_reset_rsp: got %b want 001", rsp_valid); end
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (rsp_valid !== 3'b000 || init_done !== 1'b0 || req_ready !== 3'b000) begin
         n_fail++; $display("FAIL async_reset: got v=%b init=%b ready=%b want 000/0/000", rsp_valid, init_done, req_ready);
      end
      req_valid = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      #1;
      n_chk++; if (ram_addr !== 4'd7) begin n_fail++; $display("FAIL clear_at_7: got %0d want 7", ram_addr); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (ram_addr !== 4'd0 || init_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_clear: got addr=%0d init=%b want 0/0", ram_addr, init_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         n_chk++; if (ram_addr !== 4'(c) || ram_en !== 1'b1) begin
            n_fail++; $display("FAIL reclear[%0d]: got addr=%0d en=%b want %0d/1", c, ram_addr, ram_en, c);
         end
         @(negedge clk);
      end
      #1;
      n_chk++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reclear_done: got %b want 1", init_done); end
   endtask

   task automatic test_non_pow2;
      @(negedge clk);
      rst2_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_chk++; if (ram_en2 !== 1'b1 || ram_addr2 !== 4'(c) || init_done2 !== 1'b0) begin
            n_fail++; $display("FAIL np2_clear[%0d]: got en=%b addr=%0d init=%b want 1/%0d/0", c, ram_en2, ram_addr2, init_done2, c);
         end
         @(negedge clk);
      end
      #1;
      n_chk++; if (init_done2 !== 1'b1 || ram_en2 !== 1'b0) begin
         n_fail++; $display("FAIL np2_done: got init=%b en=%b want 1/0", init_done2, ram_en2);
      end
      repeat (3) @(negedge clk);
      n_chk++; if (bad2 !== 1'b0) begin n_fail++; $display("FAIL np2_addr_range: got stray=%b want 0", bad2); end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_round_robin();
      test_single_read();
      test_back_to_back();
      test_reset_mid();
      test_non_pow2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
